// File: rtl/axi_lite_req_arbiter.sv
// Two-master round-robin arbiter in front of a single AXI-lite slave port.
// One transaction is in flight at a time; each response returns as a one-cycle pulse to its master.
module axi_lite_req_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  m_req,
  input  logic [1:0]                  m_we,
  input  logic [2*ADDR_WIDTH-1:0]     m_addr,
  input  logic [2*DATA_WIDTH-1:0]     m_wdata,
  input  logic [2*(DATA_WIDTH/8)-1:0] m_wstrb,
  output logic [1:0]                  m_gnt,
  output logic [1:0]                  m_rsp_valid,
  output logic [DATA_WIDTH-1:0]       m_rsp_rdata,
  output logic                        m_rsp_err,
  output logic                        s_awvalid,
  input  logic                        s_awready,
  output logic [ADDR_WIDTH-1:0]       s_awaddr,
  output logic                        s_wvalid,
  input  logic                        s_wready,
  output logic [DATA_WIDTH-1:0]       s_wdata,
  output logic [(DATA_WIDTH/8)-1:0]   s_wstrb,
  input  logic                        s_bvalid,
  output logic                        s_bready,
  input  logic [1:0]                  s_bresp,
  output logic                        s_arvalid,
  input  logic                        s_arready,
  output logic [ADDR_WIDTH-1:0]       s_araddr,
  input  logic                        s_rvalid,
  output logic                        s_rready,
  input  logic [DATA_WIDTH-1:0]       s_rdata,
  input  logic [1:0]                  s_rresp
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA} state_e;

  state_e                  state_q, state_d;
  logic                    ptr_q, ptr_d;
  logic                    sel_q, sel_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;
  logic [1:0]              rsp_valid_q, rsp_valid_d;
  logic                    rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

  logic grant, gnt_idx, gnt_we, aw_hs, w_hs;
  logic unused_resp_lsb;

  assign unused_resp_lsb = s_bresp[0] ^ s_rresp[0];

  // The pointer only matters when both masters contend.
  always_comb begin
    grant   = (state_q == IDLE) && (|m_req);
    gnt_idx = (m_req == 2'b11) ? ptr_q : m_req[1];
    gnt_we  = gnt_idx ? m_we[1] : m_we[0];
    aw_hs   = (state_q == WR_ADDR) && !aw_done_q && s_awready;
    w_hs    = (state_q == WR_ADDR) && !w_done_q && s_wready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      sel_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_valid_q <= '0;
      rsp_err_q   <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      sel_q       <= sel_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rdata_q     <= rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    sel_d       = sel_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    rsp_valid_d = '0;
    rsp_err_d   = rsp_err_q;
    rdata_d     = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          sel_d     = gnt_idx;
          ptr_d     = ~gnt_idx;
          addr_d    = gnt_idx ? m_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : m_addr[ADDR_WIDTH-1:0];
          wdata_d   = gnt_idx ? m_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : m_wdata[DATA_WIDTH-1:0];
          wstrb_d   = gnt_idx ? m_wstrb[2*STRB_WIDTH-1:STRB_WIDTH] : m_wstrb[STRB_WIDTH-1:0];
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = gnt_we ? WR_ADDR : RD_ADDR;
        end
      end
      WR_ADDR: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        // AW and W may finish in either order; leave once both have landed.
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = WR_RESP;
      end
      WR_RESP: begin
        if (s_bvalid) begin
          rsp_valid_d[sel_q] = 1'b1;
          rsp_err_d          = s_bresp[1];
          state_d            = IDLE;
        end
      end
      RD_ADDR: begin
        if (s_arready) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (s_rvalid) begin
          rsp_valid_d[sel_q] = 1'b1;
          rsp_err_d          = s_rresp[1];
          rdata_d            = s_rdata;
          state_d            = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant is combinational, so it is masked explicitly while reset is held.
  always_comb begin
    m_gnt = '0;
    if (grant && !rst) m_gnt[gnt_idx] = 1'b1;
    s_awvalid   = (state_q == WR_ADDR) && !aw_done_q;
    s_wvalid    = (state_q == WR_ADDR) && !w_done_q;
    s_bready    = (state_q == WR_RESP);
    s_arvalid   = (state_q == RD_ADDR);
    s_rready    = (state_q == RD_DATA);
    s_awaddr    = addr_q;
    s_araddr    = addr_q;
    s_wdata     = wdata_q;
    s_wstrb     = wstrb_q;
    m_rsp_valid = rsp_valid_q;
    m_rsp_err   = rsp_err_q;
    m_rsp_rdata = rdata_q;
  end

endmodule

// File: doc/axi_lite_req_arbiter.md
AXI_LITE_REQ_ARBITER -- requirements
Module: axi_lite_req_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, setting the address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, setting the data width; wstrb width is DATA_WIDTH/8.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 The block SHALL have the following ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- m_req  in  2  per-master request; held until granted.
- m_we  in  2  per-master write (1) or read (0).
- m_addr  in  2*ADDR_WIDTH  per-master address; master i occupies slice i.
- m_wdata  in  2*DATA_WIDTH  per-master write data.
- m_wstrb  in  2*DATA_WIDTH/8  per-master byte strobes.
- m_gnt  out  2  one-hot grant pulse.
- m_rsp_valid  out  2  one-hot response pulse.
- m_rsp_rdata  out  DATA_WIDTH  read data, shared by both masters.
- m_rsp_err  out  1  response error, equal to resp[1].
- s_awvalid / s_awready  out / in  1 / 1  AXI-lite write-address handshake.
- s_awaddr  out  ADDR_WIDTH  write address.
- s_wvalid / s_wready  out / in  1 / 1  write-data handshake.
- s_wdata  out  DATA_WIDTH  write data.
- s_wstrb  out  DATA_WIDTH/8  write strobes.
- s_bvalid / s_bready  in / out  1 / 1  write-response handshake.
- s_bresp  in  2  write response.
- s_arvalid / s_arready  out / in  1 / 1  read-address handshake.
- s_araddr  out  ADDR_WIDTH  read address.
- s_rvalid / s_rready  in / out  1 / 1  read-data handshake.
- s_rdata  in  DATA_WIDTH  read data.
- s_rresp  in  2  read response.

Function
REQ-005 The FSM SHALL have the states IDLE, WR_ADDR, WR_RESP, RD_ADDR and RD_DATA, with at most one transaction outstanding.
REQ-006 In IDLE with any m_req set, m_gnt SHALL assert combinationally that cycle for exactly one master, chosen round-robin.
REQ-007 The priority pointer SHALL favour master 0 after reset; after each grant it SHALL point to the other master.
REQ-008 On grant, addr, wdata, wstrb and we SHALL be registered; the FSM SHALL enter WR_ADDR if we=1, else RD_ADDR.
REQ-009 In WR_ADDR, s_awvalid and s_wvalid SHALL assert from the cycle after grant and each SHALL hold until its own ready handshake. AW and W complete independently, in either order or together. When both are done the FSM SHALL go to WR_RESP.
REQ-010 In WR_RESP, s_bready SHALL be 1; on s_bvalid the FSM SHALL return to IDLE.
REQ-011 In RD_ADDR, s_arvalid SHALL hold until s_arready, then the FSM SHALL go to RD_DATA.
REQ-012 In RD_DATA, s_rready SHALL be 1; on s_rvalid the block SHALL capture rdata and the FSM SHALL return to IDLE.
REQ-013 m_rsp_valid[granted] SHALL pulse one cycle, registered, in the cycle after the B or R handshake. That same cycle m_rsp_err SHALL reflect resp[1] and m_rsp_rdata SHALL be valid for reads; it is held otherwise.
REQ-014 A new grant SHALL be possible in the same cycle as m_rsp_valid. Minimum read turnaround is 3 cycles from grant to next grant.
REQ-015 A master dropping m_req before it is granted SHALL have no effect. Slave ready or response inputs outside the matching state SHALL be ignored.
REQ-016 Slave address, data and strobe outputs SHALL remain stable while the corresponding valid is high.

Reset
REQ-017 While rst is high, regardless of clk, all valid, ready, gnt and rsp outputs SHALL be 0, data outputs SHALL be 0, the state SHALL be IDLE and the pointer SHALL be 0.
REQ-018 Reset mid-transaction SHALL drop the transaction with no response pulse.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Single read, master 0, addr 0x1000_0000, slave ready immediately, rdata 0xDEADBEEF -> gnt[0] at c0, arvalid at c1, rsp_valid[0] at c3 with rdata 0xDEADBEEF, err=0.
- Write with wready 2 cycles before awready -> each valid holds until its own ready, bready=1 in WR_RESP, bresp=2'b10 gives rsp_err=1.
- Both masters requesting continuously after reset -> grants alternate 0,1,0,1.
- Master 1 alone three times -> grants go to 1 each time and the pointer never starves it.
- rst asserted during RD_DATA -> outputs 0 asynchronously, no rsp_valid; a fresh request after release is granted to master 0.
